// File: rtl/mmio_timer.sv
// rtl/mmio_timer.sv - memory-mapped countdown timer with prescaler, auto-reload and level irq
// Decodes a 16-byte window on the single-cycle CPU data bus; reads are combinational.
module mmio_timer #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
  parameter int          PRESCALE  = 4,
  parameter int          WIDTH     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwritedata,
  output logic [31:0] memreaddata,
  output logic        hit,
  output logic        irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_LOAD   = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;
  localparam logic [1:0] OFF_STATUS = 2'd3;

  logic             en;
  logic             autoreload;
  logic             irqen;
  logic             expired;
  logic [WIDTH-1:0] load;
  logic [WIDTH-1:0] count;
  logic [PW-1:0]    presc;

  logic       wr;
  logic [1:0] off;
  logic       tick;
  logic       expiry;
  logic       en_nxt;
  logic       unused_addr_bits;

  assign hit    = (memaddr[31:4] == BASE_ADDR[31:4]);
  assign off    = memaddr[3:2];
  assign wr     = memwrite & hit;
  assign tick   = en & (presc == PRESC_LAST);
  assign expiry = tick & (count == '0);
  assign irq    = expired & irqen;

  assign unused_addr_bits = ^memaddr[1:0];

  // A CTRL write overrides the one-shot auto-disable on the same edge.
  always_comb begin
    en_nxt = en;
    if (wr && off == OFF_CTRL)
      en_nxt = memwritedata[0];
    else if (expiry && !autoreload)
      en_nxt = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en         <= 1'b0;
      autoreload <= 1'b0;
      irqen      <= 1'b0;
      expired    <= 1'b0;
      load       <= '0;
      count      <= '0;
      presc      <= '0;
    end else begin
      en <= en_nxt;
      if (wr && off == OFF_CTRL) begin
        autoreload <= memwritedata[1];
        irqen      <= memwritedata[2];
      end

      // Restarting from a disabled state always begins a fresh prescale period.
      if (!en || !en_nxt)
        presc <= '0;
      else if (tick)
        presc <= '0;
      else
        presc <= presc + PW'(1);

      if (wr && off == OFF_LOAD)
        load <= memwritedata[WIDTH-1:0];

      if (wr && off == OFF_COUNT)
        count <= memwritedata[WIDTH-1:0];
      else if (tick) begin
        if (count != '0)
          count <= count - WIDTH'(1);
        else if (autoreload)
          count <= load;
      end

      if (expiry)
        expired <= 1'b1;
      else if (wr && off == OFF_STATUS && memwritedata[0])
        expired <= 1'b0;
    end
  end

  logic [31:0] load32;
  logic [31:0] count32;

  always_comb begin
    load32              = '0;
    load32[WIDTH-1:0]   = load;
    count32             = '0;
    count32[WIDTH-1:0]  = count;
    memreaddata         = '0;
    if (hit) begin
      case (off)
        OFF_CTRL:   memreaddata = {29'b0, irqen, autoreload, en};
        OFF_LOAD:   memreaddata = load32;
        OFF_COUNT:  memreaddata = count32;
        OFF_STATUS: memreaddata = {31'b0, expired};
        default:    memreaddata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// tb/tb_mmio_timer.sv - directed vector bench for mmio_timer
// Register-map vectors from a table, then timed sequences for counting corner cases.
module tb_mmio_timer;

  localparam logic [31:0] B = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] memaddr;
  logic [31:0] memwritedata;
  logic [31:0] memreaddata;
  logic        hit;
  logic        irq;

  int nvec  = 0;
  int nfail = 0;

  mmio_timer #(.BASE_ADDR(B), .PRESCALE(4), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .memaddr(memaddr),
    .memwritedata(memwritedata), .memreaddata(memreaddata), .hit(hit), .irq(irq)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_hit;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic rd(input string name, input logic [31:0] a, input logic [31:0] e);
    memwrite = 1'b0;
    memaddr  = a;
    #1;
    chk(name, memreaddata, e);
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] d);
    memwrite     = 1'b1;
    memaddr      = a;
    memwritedata = d;
    @(posedge clk);
    #1;
    memwrite = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1'b0, B + 32'h0,     32'h0,         32'h0,         1'b1, 1'b0};
    tbl[1]  = '{1'b0, B + 32'h4,     32'h0,         32'h0,         1'b1, 1'b0};
    tbl[2]  = '{1'b0, B + 32'h8,     32'h0,         32'h0,         1'b1, 1'b0};
    tbl[3]  = '{1'b0, B + 32'hC,     32'h0,         32'h0,         1'b1, 1'b0};
    tbl[4]  = '{1'b0, B + 32'h10,    32'h0,         32'h0,         1'b0, 1'b0};
    tbl[5]  = '{1'b1, B - 32'h4,     32'hFFFF_FFFF, 32'h0,         1'b0, 1'b0};
    tbl[6]  = '{1'b0, B + 32'h4,     32'h0,         32'h0,         1'b1, 1'b0};
    tbl[7]  = '{1'b0, B + 32'h8,     32'h0,         32'h0,         1'b1, 1'b0};
    tbl[8]  = '{1'b1, B + 32'h4,     32'h1234_5678, 32'h0,         1'b1, 1'b0};
    tbl[9]  = '{1'b0, B + 32'h4,     32'h0,         32'h1234_5678, 1'b1, 1'b0};
    tbl[10] = '{1'b1, B + 32'h8,     32'h0000_ABCD, 32'h0,         1'b1, 1'b0};
    tbl[11] = '{1'b0, B + 32'hA,     32'h0,         32'h0000_ABCD, 1'b1, 1'b0};
    tbl[12] = '{1'b1, B + 32'h0,     32'hFFFF_FFF6, 32'h0,         1'b1, 1'b0};
    tbl[13] = '{1'b0, B + 32'h3,     32'h0,         32'h6,         1'b1, 1'b0};
    tbl[14] = '{1'b0, B + 32'h8,     32'h0,         32'h0000_ABCD, 1'b1, 1'b0};
    tbl[15] = '{1'b1, B + 32'hC,     32'h1,         32'h0,         1'b1, 1'b0};
    tbl[16] = '{1'b0, B + 32'hC,     32'h0,         32'h0,         1'b1, 1'b0};
    tbl[17] = '{1'b1, B + 32'h0,     32'h0,         32'h6,         1'b1, 1'b0};
    tbl[18] = '{1'b0, B + 32'h0,     32'h0,         32'h0,         1'b1, 1'b0};
    tbl[19] = '{1'b0, 32'h7FFF_0008, 32'h0,         32'h0,         1'b0, 1'b0};

    reset        = 1'b1;
    memwrite     = 1'b0;
    memaddr      = B;
    memwritedata = 32'h0;
    cyc(2);
    reset = 1'b0;

    foreach (tbl[i]) begin
      memwrite     = tbl[i].we;
      memaddr      = tbl[i].addr;
      memwritedata = tbl[i].wdata;
      #1;
      chk($sformatf("vec%0d rdata", i), memreaddata, tbl[i].exp_rd);
      chk($sformatf("vec%0d hit", i), {31'b0, hit}, {31'b0, tbl[i].exp_hit});
      chk($sformatf("vec%0d irq", i), {31'b0, irq}, {31'b0, tbl[i].exp_irq});
      @(posedge clk);
      #1;
      memwrite = 1'b0;
    end

    // Auto-reload: 4 ticks of 4 clocks between expiries.
    bus(B + 32'h4, 32'd3);
    bus(B + 32'h8, 32'd3);
    bus(B + 32'h0, 32'h7);
    cyc(15);
    rd("ar status before 16", B + 32'hC, 32'h0);
    chk("ar irq before 16", {31'b0, irq}, 32'h0);
    cyc(1);
    rd("ar status at 16", B + 32'hC, 32'h1);
    chk("ar irq at 16", {31'b0, irq}, 32'h1);
    rd("ar count reloaded", B + 32'h8, 32'd3);
    rd("ar ctrl kept", B + 32'h0, 32'h7);
    bus(B + 32'hC, 32'h1);
    chk("ar irq cleared", {31'b0, irq}, 32'h0);
    cyc(14);
    rd("ar status before 32", B + 32'hC, 32'h0);
    cyc(1);
    rd("ar status at 32", B + 32'hC, 32'h1);

    // Clear landing on the expiry edge loses to the set.
    cyc(15);
    bus(B + 32'hC, 32'h1);
    rd("clr on expiry", B + 32'hC, 32'h1);

    // COUNT write landing on a tick edge wins over the decrement.
    cyc(3);
    bus(B + 32'h8, 32'd7);
    rd("count write on tick", B + 32'h8, 32'd7);
    cyc(3);
    rd("count holds until tick", B + 32'h8, 32'd7);
    cyc(1);
    rd("count decrements", B + 32'h8, 32'd6);

    bus(B + 32'h0, 32'h3);
    chk("irq masked by irqen", {31'b0, irq}, 32'h0);

    // Reset mid-run.
    bus(B + 32'h8, 32'd5);
    reset = 1'b1;
    cyc(1);
    reset = 1'b0;
    rd("rst ctrl", B + 32'h0, 32'h0);
    rd("rst load", B + 32'h4, 32'h0);
    rd("rst count", B + 32'h8, 32'h0);
    rd("rst status", B + 32'hC, 32'h0);
    chk("rst irq", {31'b0, irq}, 32'h0);
    cyc(10);
    rd("rst stopped", B + 32'h8, 32'h0);

    // One-shot: expiry after 3 ticks, then auto-disable.
    bus(B + 32'h4, 32'd2);
    bus(B + 32'h8, 32'd2);
    bus(B + 32'h0, 32'h1);
    cyc(11);
    rd("os status before 12", B + 32'hC, 32'h0);
    rd("os ctrl before 12", B + 32'h0, 32'h1);
    rd("os count before 12", B + 32'h8, 32'h0);
    cyc(1);
    rd("os status at 12", B + 32'hC, 32'h1);
    rd("os ctrl cleared", B + 32'h0, 32'h0);
    rd("os count zero", B + 32'h8, 32'h0);
    chk("os irq off", {31'b0, irq}, 32'h0);
    bus(B + 32'hC, 32'h1);
    cyc(20);
    rd("os no further expiry", B + 32'hC, 32'h0);
    rd("os count stays", B + 32'h8, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
